// File: rtl/adc_capture_deadlock_pkg.sv
// Shared types and constants for the ADC capture deadlock reporter.
package adc_capture_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        LATCHED = 2'd2
    } state_t;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    localparam int DEF_INFO_W = 4;
    localparam int DEF_TS_W   = 32;

    // Record layout for the default build; the top re-declares it with its own widths.
    typedef struct packed {
        logic [DEF_INFO_W-1:0] info;
        logic [DEF_TS_W-1:0]   ts;
    } rpt_rec_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == SAT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/adc_capture_deadlock_report_fifo.sv
// Report FIFO with a registered output stage; a write into an empty FIFO bypasses
// straight into the output register so it is visible on the following cycle.
module adc_capture_deadlock_report_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [CW-1:0] w_ram_cnt;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_load;
    logic          w_ram_rd;
    logic          w_bypass;
    logic          w_ram_wr;

    // r_count covers the output register too, so the array never holds more than DEPTH-1.
    assign w_ram_cnt = r_count - CW'(r_out_valid);
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = ~r_out_valid;
    assign rd_data   = r_out_data;

    assign w_pop     = pop & r_out_valid;
    assign w_push_ok = push & (~full | w_pop);
    assign w_load    = w_pop | ~r_out_valid;
    assign w_ram_rd  = w_load & (w_ram_cnt != '0);
    assign w_bypass  = w_load & (w_ram_cnt == '0) & w_push_ok;
    assign w_ram_wr  = w_push_ok & ~w_bypass;

    always_ff @(posedge clock) begin
        if (w_ram_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_load) begin
                if (w_ram_rd) begin
                    r_out_data  <= r_mem[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_out_data  <= wr_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/adc_capture_deadlock_reporter.sv
// Qualifies the deadlock monitor's block flag, timestamps confirmed events and streams
// {info, ts} records out. Define ADC_CAPTURE_DEADLOCK_TS_EN to enable the timestamp.
module adc_capture_deadlock_reporter #(
    parameter int N_AXIS         = 2,
    parameter int PERSIST_CYCLES = 4,
    parameter int TS_W           = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       block,
    input  logic [2*N_AXIS-1:0]        axis_block_info,
    input  logic                       clear,
    output logic [2*N_AXIS+TS_W-1:0]   rpt_data,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic                       deadlock_seen,
    output logic [7:0]                 event_cnt,
    output logic [7:0]                 drop_cnt,
    output logic                       irq
);

    import adc_capture_deadlock_pkg::*;

    localparam int         INFO_W  = 2 * N_AXIS;
    localparam int         REC_W   = INFO_W + TS_W;
    localparam logic [7:0] PERSIST = 8'(PERSIST_CYCLES);

    typedef struct packed {
        logic [INFO_W-1:0] info;
        logic [TS_W-1:0]   ts;
    } rec_t;

    state_t         r_state;
    logic [7:0]     r_run;
    logic           r_seen;
    logic [7:0]     r_event_cnt;
    logic [7:0]     r_drop_cnt;

    logic [TS_W-1:0] w_rec_ts;
    rec_t            w_rec;
    logic            w_confirm;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic [REC_W-1:0] w_rd_data;

`ifdef ADC_CAPTURE_DEADLOCK_TS_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_start;

    // The timestamp counter keeps running across clear; only reset zeroes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts_cnt   <= '0;
            r_ts_start <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (r_state == IDLE && block) begin
                r_ts_start <= r_ts_cnt;
            end
        end
    end

    // With single-cycle persistence the start cycle is the confirming cycle itself.
    assign w_rec_ts = (r_state == IDLE) ? r_ts_cnt : r_ts_start;
`else
    assign w_rec_ts = '0;
`endif

    assign w_confirm = block &
                       (((r_state == IDLE) && (PERSIST == 8'd1)) ||
                        ((r_state == QUALIFY) && (r_run == PERSIST - 8'd1)));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_state <= IDLE;
            r_run   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (block) begin
                        r_run   <= 8'd1;
                        r_state <= (PERSIST == 8'd1) ? LATCHED : QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (!block) begin
                        r_state <= IDLE;
                    end else begin
                        r_run <= r_run + 8'd1;
                        if (w_confirm) begin
                            r_state <= LATCHED;
                        end
                    end
                end
                LATCHED: begin
                    if (!block) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_rec.info = axis_block_info;
    assign w_rec.ts   = w_rec_ts;

    assign w_push = w_confirm & ~clear;
    assign w_pop  = ~w_empty & rpt_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    adc_capture_deadlock_report_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (clear),
        .push    (w_push),
        .wr_data (w_rec),
        .full    (w_full),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .empty   (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_seen      <= 1'b0;
            r_event_cnt <= 8'd0;
            r_drop_cnt  <= 8'd0;
        end else begin
            if (w_push) begin
                r_seen      <= 1'b1;
                r_event_cnt <= sat_inc(r_event_cnt);
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign rpt_data      = w_rd_data;
    assign rpt_valid     = ~w_empty;
    assign deadlock_seen = r_seen;
    assign irq           = r_seen;
    assign event_cnt     = r_event_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_adc_capture_deadlock_reporter.sv
// Directed bench for adc_capture_deadlock_reporter: a per-cycle vector table for the
// basic qualify/glitch behaviour plus hand-written overflow, clear and reset sequences.
module tb_adc_capture_deadlock_reporter;

    localparam int N_AXIS = 2;
    localparam int P      = 4;
    localparam int TS_W   = 32;
    localparam int DEPTH  = 4;
    localparam int REC_W  = 2 * N_AXIS + TS_W;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             block = 1'b0;
    logic [3:0]       axis_block_info = 4'h0;
    logic             clear = 1'b0;
    logic             rpt_ready = 1'b0;
    logic [REC_W-1:0] rpt_data;
    logic             rpt_valid;
    logic             deadlock_seen;
    logic [7:0]       event_cnt;
    logic [7:0]       drop_cnt;
    logic             irq;

    adc_capture_deadlock_reporter #(
        .N_AXIS         (N_AXIS),
        .PERSIST_CYCLES (P),
        .TS_W           (TS_W),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_info (axis_block_info),
        .clear           (clear),
        .rpt_data        (rpt_data),
        .rpt_valid       (rpt_valid),
        .rpt_ready       (rpt_ready),
        .deadlock_seen   (deadlock_seen),
        .event_cnt       (event_cnt),
        .drop_cnt        (drop_cnt),
        .irq             (irq)
    );

    always #5 clock = ~clock;

    // Reference cycle count since reset release.
    logic [31:0] tb_ts;
    always @(posedge clock) begin
        if (reset) tb_ts <= 32'd0;
        else       tb_ts <= tb_ts + 32'd1;
    end

    typedef struct {
        logic       blk;
        logic [3:0] info;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_ev;
        logic       exp_seen;
        logic       chk_data;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ets(input logic [31:0] t);
`ifdef ADC_CAPTURE_DEADLOCK_TS_EN
        return t;
`else
        return t & 32'h0;
`endif
    endfunction

    task automatic add(input logic blk, input logic [3:0] info, input logic rdy,
                       input logic v, input logic [7:0] ev, input logic seen, input logic cd);
        vec_t r;
        r.blk = blk; r.info = info; r.rdy = rdy;
        r.exp_valid = v; r.exp_ev = ev; r.exp_seen = seen; r.chk_data = cd;
        vq.push_back(r);
    endtask

    // One block pulse of 'hi' cycles then one low cycle; optionally accept on the confirm edge.
    task automatic pulse(input logic [3:0] inf, input int hi, input bit pop_conf,
                         output logic [REC_W-1:0] rec);
        rec = {inf, ets(tb_ts)};
        for (int c = 0; c < hi; c++) begin
            block = 1'b1;
            axis_block_info = inf;
            rpt_ready = pop_conf && (c == P - 1);
            step();
        end
        block = 1'b0;
        axis_block_info = 4'h0;
        rpt_ready = 1'b0;
        step();
    endtask

    logic [REC_W-1:0] d_rec;
    logic [REC_W-1:0] rec_t0;
    logic [REC_W-1:0] ovf[6];
    logic [REC_W-1:0] drain_q[4];
    logic [31:0]      t0;

    initial begin
        d_rec = {4'b1101, ets(32'd100)};

        // Qualify and report, then glitch rejection, one row per clock.
        for (int i = 0; i < 3; i++) add(1, 4'b1101, 0, 0, 8'd0, 0, 0);
        add(1, 4'b1101, 0, 1, 8'd1, 1, 1);
        for (int i = 0; i < 6; i++) add(1, 4'b1101, 0, 1, 8'd1, 1, 0);
        add(0, 4'h0, 0, 1, 8'd1, 1, 1);
        add(0, 4'h0, 1, 0, 8'd1, 1, 0);
        for (int i = 0; i < 3; i++) add(1, 4'b0110, 0, 0, 8'd1, 1, 0);
        add(0, 4'h0, 0, 0, 8'd1, 1, 0);
        for (int i = 0; i < 2; i++) add(1, 4'b0110, 0, 0, 8'd1, 1, 0);
        add(0, 4'h0, 0, 0, 8'd1, 1, 0);

        repeat (3) step();
        chk("reset_state", {rpt_valid, rpt_data, deadlock_seen, irq, event_cnt, drop_cnt}, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 200 && tb_ts != 32'd100; i++) step();

        foreach (vq[i]) begin
            block = vq[i].blk;
            axis_block_info = vq[i].info;
            rpt_ready = vq[i].rdy;
            step();
            chk($sformatf("vec%0d_status", i),
                {rpt_valid, event_cnt, deadlock_seen, irq, drop_cnt},
                {vq[i].exp_valid, vq[i].exp_ev, vq[i].exp_seen, vq[i].exp_seen, 8'h0});
            if (vq[i].chk_data) chk($sformatf("vec%0d_data", i), rpt_data, d_rec);
        end
        block = 1'b0;
        axis_block_info = 4'h0;
        rpt_ready = 1'b0;

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_status", {event_cnt, drop_cnt, deadlock_seen, irq, rpt_valid}, 64'h0);

        // Overflow: six events into a four-deep buffer with the consumer stalled.
        for (int i = 0; i < 6; i++) pulse(4'(i + 1), 5, 0, ovf[i]);
        chk("ovf_events", event_cnt, 8'd6);
        chk("ovf_drops", drop_cnt, 8'd2);
        chk("ovf_head", {rpt_valid, rpt_data}, {1'b1, ovf[0]});

        // Full buffer with a pop on the confirming edge: no drop.
        pulse(4'h7, 5, 1, rec_t0);
        chk("fullpop_drops", drop_cnt, 8'd2);
        chk("fullpop_events", event_cnt, 8'd7);
        drain_q[0] = ovf[1];
        drain_q[1] = ovf[2];
        drain_q[2] = ovf[3];
        drain_q[3] = rec_t0;

        rpt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d", j), {rpt_valid, rpt_data}, {1'b1, drain_q[j]});
            step();
        end
        rpt_ready = 1'b0;
        chk("drain_empty", rpt_valid, 1'b0);

        // Leave one record pending so the clear must flush it.
        pulse(4'h9, 5, 0, rec_t0);
        chk("pending_rec", {rpt_valid, rpt_data}, {1'b1, rec_t0});

        // Clear on the confirming edge with block still high: restart from IDLE.
        t0 = tb_ts;
        for (int c = 0; c < 8; c++) begin
            block = 1'b1;
            axis_block_info = 4'hA;
            clear = (c == 3);
            step();
            clear = 1'b0;
            if (c == 3)
                chk("clear_on_confirm",
                    {event_cnt, drop_cnt, deadlock_seen, irq, rpt_valid}, 64'h0);
        end
        block = 1'b0;
        axis_block_info = 4'h0;
        step();
        chk("requalify_status", {event_cnt, drop_cnt, deadlock_seen, irq},
            {8'd1, 8'd0, 1'b1, 1'b1});
        chk("requalify_rec", {rpt_valid, rpt_data}, {1'b1, 4'hA, ets(t0 + 32'd4)});

        // Saturation of both counters.
        for (int i = 0; i < 260; i++) pulse(4'h3, 4, 0, rec_t0);
        chk("sat_events", event_cnt, 8'hFF);
        chk("sat_drops", drop_cnt, 8'hFF);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midop_reset", {rpt_valid, rpt_data, deadlock_seen, irq, event_cnt, drop_cnt}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_deadlock_reporter.md
# adc_capture_deadlock_reporter

Consumer end of the HLS deadlock-monitor output (`block`, `axis_block_info`). It qualifies the monitor's registered `block` flag, timestamps each confirmed deadlock and records which AXIS channels were stalled. Records are buffered and delivered to the control/PS side over a valid/ready stream, along with sticky status, event and drop counters, and an interrupt. It sits beside the ADC capture dataflow instance, one reporter per monitor.

## Interface
- `N_AXIS`, default 2: number of AXIS channels watched by the monitor. Info width INFO_W = 2*N_AXIS.
- `PERSIST_CYCLES`, default 4: consecutive cycles `block` must be high to confirm a deadlock. Legal range 1..255.
- `TS_W`, default 32: timestamp counter width.
- `FIFO_DEPTH`, default 4: report buffer depth. Must be a power of two, ≥2.
- `clock` in 1: clock; all logic on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `block` in 1: deadlock flag from the monitor.
- `axis_block_info` in INFO_W: per-channel 2-bit field. A field is nonzero when that channel is blocked; the field is zero whenever `block` is low.
- `clear` in 1: single-cycle pulse. Clears sticky status and counters and flushes the FIFO.
- `rpt_data` out INFO_W+TS_W: record `{info, ts}`, info in the MSBs.
- `rpt_valid` out 1: record available.
- `rpt_ready` in 1: consumer accepts the record.
- `deadlock_seen` out 1: sticky; set on the first confirmation.
- `event_cnt` out 8: confirmed events, saturating at 255.
- `drop_cnt` out 8: records lost to a full FIFO, saturating at 255.
- `irq` out 1: level output, equal to `deadlock_seen`.

## Operation
- A free-running counter `ts_cnt` (TS_W bits) increments every cycle and wraps modulo 2^TS_W.
- FSM states and transitions:
  - IDLE: when `block`=1, capture `ts_start`=`ts_cnt`, set `run`=1 and go to QUALIFY. If PERSIST_CYCLES=1, confirm immediately and go to LATCHED.
  - QUALIFY: while `block`=1, increment `run`. When `run` reaches PERSIST_CYCLES, confirm and go to LATCHED. If `block`=0 first, return to IDLE with nothing recorded.
  - LATCHED: wait for `block`=0, then return to IDLE. One record is produced per contiguous `block` assertion.
- Confirmation actions, all on the same edge:
  - Write `{axis_block_info, ts_start}` to the FIFO; `axis_block_info` is sampled on the confirming edge.
  - Set `deadlock_seen`.
  - Increment `event_cnt`.
- If the FIFO is full on a write and no pop happens on the same edge, the record is discarded and `drop_cnt` increments. A pop and a push on the same edge while full both succeed.
- Stream rules:
  - A record transfers on an edge where `rpt_valid`&`rpt_ready` are both high.
  - Once `rpt_valid` is asserted, `rpt_data` holds stable until the transfer.
  - `rpt_valid` never depends combinationally on `rpt_ready`.
- `clear` has priority over every event in the same cycle:
  - Counters, sticky status and FIFO are zeroed.
  - The FSM goes to IDLE, and a confirmation coinciding with `clear` is discarded.
  - `ts_cnt` is not cleared.
- If `block` is already high when `clear` drops, qualification restarts from IDLE.

## Timing
- Reset values: `rpt_valid`=0, `rpt_data`=0, `deadlock_seen`=0, `irq`=0, `event_cnt`=0, `drop_cnt`=0, `ts_cnt`=0, FSM=IDLE. Reset asserted mid-operation discards every pending record.
- Latency, when `block` is first sampled high at edge k and stays high:
  - Confirmation occurs at edge k+PERSIST_CYCLES−1.
  - With the FIFO empty, `rpt_valid` is high in the cycle after that edge.
  - `deadlock_seen` and `irq` rise in that same cycle.
- The FIFO output is registered: a record written to an empty FIFO is visible on the next cycle.
- Throughput is one pop per cycle.
- Counters saturate at 255 and never wrap.

## Configuration
- `ADC_CAPTURE_DEADLOCK_TS_EN` defined: `ts_cnt` and `ts_start` are present and the ts field carries the confirmation-start cycle.
- `ADC_CAPTURE_DEADLOCK_TS_EN` undefined:
  - The counter is removed.
  - The ts field of `rpt_data` is tied to zero; port widths are unchanged.
  - All other behaviour is identical.

## Structure
- Package `adc_capture_deadlock_pkg` holds:
  - the FSM state enum (IDLE, QUALIFY, LATCHED);
  - the saturation limit constant 8'hFF;
  - the record struct typedef parameterised by INFO_W/TS_W widths.
- Sub-module `adc_capture_deadlock_report_fifo`: synchronous FIFO with registered output, parameters width and depth, ports push, pop, full, empty and flush.

## Test plan
- **Qualify and report.** PERSIST=4, TS_EN; `block`=1 for 10 cycles starting at `ts_cnt`=100, info=4'b1101. Required: one record `{4'b1101, 100}`, `rpt_valid` high 4 cycles after the first high sample, `event_cnt`=1, `irq`=1.
- **Glitch rejection.** `block` high for 3 cycles, low, then high for 2 cycles. Required: no record, `event_cnt`=0.
- **Overflow.** `rpt_ready`=0; 6 separate 5-cycle `block` pulses. Required: 4 records buffered, `drop_cnt`=2, `event_cnt`=6; draining delivers ts values in order.
- **Full FIFO with simultaneous pop.** FIFO full; a confirmation lands on the same edge as a transfer. Required: no drop, 4 records remain buffered.
- **Clear priority.** `clear` on the confirming edge. Required: no record, all counters 0, `deadlock_seen`=0, next `block` pulse is qualified normally.
- **TS_EN off.** Repeat scenario 1 with the macro undefined. Required: record `{4'b1101, 0}`.
